// File: rtl/avg_pkg.sv
// Shared widths, FSM state type and the delta helper for the line drawer.
package avg_pkg;
  localparam int COORD_W = 11;
  localparam int COLOR_W = 3;
  localparam int DELTA_W = COORD_W + 1;
  localparam int ERR_W   = 14;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    DRAW  = 2'd2
  } avg_state_t;

  typedef logic signed [COORD_W-1:0] coord_t;

  function automatic logic [DELTA_W-1:0] abs_diff(input coord_t a, input coord_t b);
    logic signed [DELTA_W-1:0] d;
    d = DELTA_W'(a) - DELTA_W'(b);
    return d[DELTA_W-1] ? DELTA_W'(-d) : DELTA_W'(d);
  endfunction
endpackage

// File: rtl/avg_line_drawer_if.sv
// Line-queue pop port and framebuffer pixel port of the line drawer.
interface avg_line_drawer_if;
  import avg_pkg::*;

  coord_t             qStartX, qStartY, qEndX, qEndY;
  logic [COLOR_W-1:0] qColor;
  logic               qEmpty;
  logic               qRead;
  logic [COORD_W-1:0] pxX, pxY;
  logic [COLOR_W-1:0] pxColor;
  logic               pxWrite;
  logic               pxReady;

  modport master (
    input  qStartX, qStartY, qEndX, qEndY, qColor, qEmpty, pxReady,
    output qRead, pxX, pxY, pxColor, pxWrite
  );

  modport slave (
    output qStartX, qStartY, qEndX, qEndY, qColor, qEmpty, pxReady,
    input  qRead, pxX, pxY, pxColor, pxWrite
  );
endinterface

// File: rtl/avg_clip.sv
// Maps a centre-origin point to framebuffer coordinates and flags on-screen points.
module avg_clip
  import avg_pkg::*;
#(
  parameter int SCR_W = 640,
  parameter int SCR_H = 480
) (
  input  coord_t             x,
  input  coord_t             y,
  output logic [COORD_W-1:0] scr_x,
  output logic [COORD_W-1:0] scr_y,
  output logic               visible
);
  localparam int SW = COORD_W + 2;

  logic signed [SW-1:0] wx, wy;

  // Screen Y grows downward, so the world Y axis is flipped.
  assign wx = SW'(x) + SW'(SCR_W / 2);
  assign wy = SW'(SCR_H / 2) - SW'(y);

  assign scr_x   = wx[COORD_W-1:0];
  assign scr_y   = wy[COORD_W-1:0];
  assign visible = !wx[SW-1] && (wx < SW'(SCR_W)) &&
                   !wy[SW-1] && (wy < SW'(SCR_H));
endmodule

// File: rtl/avg_line_drawer.sv
// Pops lines from a queue and walks them with Bresenham, emitting on-screen pixels.
// state | meaning
// IDLE  | waiting for a queued line; pops and latches it when one is present
// SETUP | derive deltas, step signs and initial error; present first point
// DRAW  | present current point, step on acceptance or when it is off-screen
module avg_line_drawer
  import avg_pkg::*;
#(
  parameter int SCR_W = 640,
  parameter int SCR_H = 480
) (
  input  logic               clk,
  input  logic               rst_b,
  avg_line_drawer_if.master  bus,
  output logic               busy
);
  avg_state_t               state;
  coord_t                   cur_x, cur_y, end_x, end_y;
  logic [COLOR_W-1:0]       color;
  logic [DELTA_W-1:0]       dx, dy;
  logic                     sx_neg, sy_neg;
  logic signed [ERR_W-1:0]  err;
  logic [COORD_W-1:0]       px_x, px_y;
  logic [COLOR_W-1:0]       px_color;
  logic                     px_write;

  logic signed [ERR_W:0]    e2, dx_e, dy_e;
  logic                     step_x, step_y, at_end, advance, visible;
  coord_t                   nxt_x, nxt_y;
  logic signed [ERR_W-1:0]  nxt_err;
  logic [COORD_W-1:0]       scr_x, scr_y;
  logic [DELTA_W-1:0]       set_dx, set_dy;

  // Outside DRAW the next point is the current one, so SETUP presents the start point.
  always_comb begin
    e2      = {err, 1'b0};
    dx_e    = (ERR_W+1)'(dx);
    dy_e    = (ERR_W+1)'(dy);
    step_x  = (state == DRAW) && (e2 > -dy_e);
    step_y  = (state == DRAW) && (e2 < dx_e);
    nxt_x   = cur_x;
    nxt_y   = cur_y;
    nxt_err = err;
    if (step_x) begin
      nxt_x   = sx_neg ? cur_x - coord_t'(1) : cur_x + coord_t'(1);
      nxt_err = nxt_err - ERR_W'(dy);
    end
    if (step_y) begin
      nxt_y   = sy_neg ? cur_y - coord_t'(1) : cur_y + coord_t'(1);
      nxt_err = nxt_err + ERR_W'(dx);
    end
  end

  assign set_dx  = abs_diff(end_x, cur_x);
  assign set_dy  = abs_diff(end_y, cur_y);
  assign at_end  = (cur_x == end_x) && (cur_y == end_y);
  assign advance = !px_write || bus.pxReady;

  // Queue head is combinational, so the pop strobe must be too; held low in reset.
  assign bus.qRead   = rst_b && (state == IDLE) && !bus.qEmpty;
  assign bus.pxX     = px_x;
  assign bus.pxY     = px_y;
  assign bus.pxColor = px_color;
  assign bus.pxWrite = px_write;

  avg_clip #(.SCR_W(SCR_W), .SCR_H(SCR_H)) u_clip (
    .x       (nxt_x),
    .y       (nxt_y),
    .scr_x   (scr_x),
    .scr_y   (scr_y),
    .visible (visible)
  );

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state    <= IDLE;
      busy     <= 1'b0;
      cur_x    <= '0;
      cur_y    <= '0;
      end_x    <= '0;
      end_y    <= '0;
      color    <= '0;
      dx       <= '0;
      dy       <= '0;
      sx_neg   <= 1'b0;
      sy_neg   <= 1'b0;
      err      <= '0;
      px_x     <= '0;
      px_y     <= '0;
      px_color <= '0;
      px_write <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (!bus.qEmpty) begin
            cur_x <= bus.qStartX;
            cur_y <= bus.qStartY;
            end_x <= bus.qEndX;
            end_y <= bus.qEndY;
            color <= bus.qColor;
            state <= SETUP;
            busy  <= 1'b1;
          end
        end
        SETUP: begin
          dx       <= set_dx;
          dy       <= set_dy;
          sx_neg   <= end_x < cur_x;
          sy_neg   <= end_y < cur_y;
          err      <= ERR_W'(set_dx) - ERR_W'(set_dy);
          px_x     <= scr_x;
          px_y     <= scr_y;
          px_color <= color;
          px_write <= visible;
          state    <= DRAW;
        end
        DRAW: begin
          if (advance) begin
            if (at_end) begin
              state    <= IDLE;
              busy     <= 1'b0;
              px_write <= 1'b0;
            end else begin
              cur_x    <= nxt_x;
              cur_y    <= nxt_y;
              err      <= nxt_err;
              px_x     <= scr_x;
              px_y     <= scr_y;
              px_write <= visible;
            end
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_avg_line_drawer.sv
// Directed bench for avg_line_drawer: queue model, pixel logger and expected pixel lists.
module tb_avg_line_drawer;
  import avg_pkg::*;

  logic clk = 1'b0;
  logic rst_b = 1'b0;
  logic busy;

  always #5 clk = ~clk;

  avg_line_drawer_if bus ();

  avg_line_drawer #(.SCR_W(640), .SCR_H(480)) dut (
    .clk   (clk),
    .rst_b (rst_b),
    .bus   (bus.master),
    .busy  (busy)
  );

  int qx0[16], qy0[16], qx1[16], qy1[16], qc[16];
  int q_wr = 0;
  int q_rd = 0;

  assign bus.qEmpty  = (q_rd == q_wr);
  assign bus.qStartX = coord_t'(qx0[q_rd[3:0]]);
  assign bus.qStartY = coord_t'(qy0[q_rd[3:0]]);
  assign bus.qEndX   = coord_t'(qx1[q_rd[3:0]]);
  assign bus.qEndY   = coord_t'(qy1[q_rd[3:0]]);
  assign bus.qColor  = 3'(qc[q_rd[3:0]]);

  always @(posedge clk) if (bus.qRead) q_rd <= q_rd + 1;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [24:0] px_log [128];
  int          px_cyc [128];
  int          n_px = 0;
  int          qr_cyc [32];
  int          n_qr = 0;
  int          qr_bad = 0;
  logic        prev_qr = 1'b0;

  always @(negedge clk) begin
    if (bus.pxWrite && bus.pxReady && n_px < 128) begin
      px_log[n_px] <= {bus.pxX, bus.pxY, bus.pxColor};
      px_cyc[n_px] <= cyc;
      n_px         <= n_px + 1;
    end
    if (bus.qRead && n_qr < 32) begin
      if (prev_qr || busy) qr_bad <= qr_bad + 1;
      qr_cyc[n_qr] <= cyc;
      n_qr         <= n_qr + 1;
    end
    prev_qr <= bus.qRead;
  end

  int n_tests = 0;
  int n_fail  = 0;
  int done_cyc = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] pk(input int x, input int y, input int c);
    return {7'd0, 11'(x), 11'(y), 3'(c)};
  endfunction

  task automatic expect_px(input string tag, input int idx, input int x, input int y, input int c);
    check(tag, {7'd0, px_log[idx]}, pk(x, y, c));
  endtask

  task automatic push(input int x0, input int y0, input int x1, input int y1, input int c);
    qx0[q_wr[3:0]] = x0;
    qy0[q_wr[3:0]] = y0;
    qx1[q_wr[3:0]] = x1;
    qy1[q_wr[3:0]] = y1;
    qc[q_wr[3:0]]  = c;
    q_wr++;
  endtask

  task automatic wait_done(input string tag);
    int k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!(bus.qEmpty && !busy) && k < 300);
    done_cyc = cyc;
    check({tag, "_timeout"}, 32'(k >= 300), 32'd0);
  endtask

  task automatic wait_px(input string tag);
    int k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!bus.pxWrite && k < 100);
    check({tag, "_px_timeout"}, 32'(k >= 100), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int b, bq, np;

    bus.pxReady = 1'b1;
    rst_b = 1'b0;
    push(0, 0, 3, 0, 5);
    repeat (3) @(negedge clk);
    check("rst_qRead",   32'(bus.qRead),   32'd0);
    check("rst_busy",    32'(busy),        32'd0);
    check("rst_pxWrite", 32'(bus.pxWrite), 32'd0);
    check("rst_pixel",   pk(bus.pxX, bus.pxY, bus.pxColor), pk(0, 0, 0));

    // Line A: horizontal, one pixel per cycle, 2-cycle latency from pop.
    b = n_px; bq = n_qr;
    @(posedge clk); #1 rst_b = 1'b1;
    wait_done("A");
    check("A_count", 32'(n_px - b), 32'd4);
    check("A_latency", 32'(px_cyc[b] - qr_cyc[bq]), 32'd2);
    expect_px("A_px0", b,     320, 240, 5);
    expect_px("A_px1", b + 1, 321, 240, 5);
    expect_px("A_px2", b + 2, 322, 240, 5);
    expect_px("A_px3", b + 3, 323, 240, 5);
    check("A_consecutive", 32'(px_cyc[b + 3] - px_cyc[b]), 32'd3);
    check("A_busy_fall", 32'(done_cyc - px_cyc[b + 3]), 32'd1);

    // Lines B (diagonal) and C (single point).
    b = n_px;
    @(posedge clk); #1;
    push(0, 0, 2, 2, 2);
    push(5, 5, 5, 5, 7);
    wait_done("BC");
    check("BC_count", 32'(n_px - b), 32'd4);
    expect_px("B_px0", b,     320, 240, 2);
    expect_px("B_px1", b + 1, 321, 239, 2);
    expect_px("B_px2", b + 2, 322, 238, 2);
    expect_px("C_px0", b + 3, 325, 235, 7);

    // Line G: steep, negative x step.
    b = n_px;
    @(posedge clk); #1;
    push(3, -1, 1, 3, 6);
    wait_done("G");
    check("G_count", 32'(n_px - b), 32'd5);
    expect_px("G_px0", b,     323, 241, 6);
    expect_px("G_px1", b + 1, 323, 240, 6);
    expect_px("G_px2", b + 2, 322, 239, 6);
    expect_px("G_px3", b + 3, 322, 238, 6);
    expect_px("G_px4", b + 4, 321, 237, 6);

    // Line D: framebuffer stalls for 3 cycles on the third pixel.
    b = n_px;
    @(posedge clk); #1;
    push(10, -3, 14, -3, 3);
    wait_px("D");
    @(posedge clk);
    @(posedge clk); #1 bus.pxReady = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("D_hold_write", 32'(bus.pxWrite), 32'd1);
      check("D_hold_pixel", pk(bus.pxX, bus.pxY, bus.pxColor), pk(332, 243, 3));
    end
    @(posedge clk); #1 bus.pxReady = 1'b1;
    wait_done("D");
    check("D_count", 32'(n_px - b), 32'd5);
    expect_px("D_px0", b,     330, 243, 3);
    expect_px("D_px1", b + 1, 331, 243, 3);
    expect_px("D_px2", b + 2, 332, 243, 3);
    expect_px("D_px3", b + 3, 333, 243, 3);
    expect_px("D_px4", b + 4, 334, 243, 3);

    // Off-screen line E then single point F, queued back to back.
    b = n_px; bq = n_qr;
    @(posedge clk); #1;
    push(400, 0, 402, 0, 1);
    push(0, 0, 0, 0, 4);
    wait_done("EF");
    check("EF_pops", 32'(n_qr - bq), 32'd2);
    check("EF_pop_gap", 32'(qr_cyc[bq + 1] - qr_cyc[bq]), 32'd5);
    check("EF_count", 32'(n_px - b), 32'd1);
    expect_px("F_px0", b, 320, 240, 4);

    // Screen corners: last visible pixel before leaving the frame.
    b = n_px;
    @(posedge clk); #1;
    push(319, -239, 320, -240, 1);
    push(-320, 240, -321, 240, 2);
    wait_done("corner");
    check("corner_count", 32'(n_px - b), 32'd2);
    expect_px("corner_br", b,     639, 479, 1);
    expect_px("corner_tl", b + 1, 0,   0,   2);

    // Extreme coordinate, entirely off-screen: 4 DRAW cycles, no pixels.
    b = n_px; bq = n_qr;
    @(posedge clk); #1;
    push(1020, 0, 1023, 0, 6);
    wait_done("X");
    check("X_count", 32'(n_px - b), 32'd0);
    check("X_duration", 32'(done_cyc - qr_cyc[bq]), 32'd6);
    check("qread_protocol", 32'(qr_bad), 32'd0);

    // Reset mid-line abandons it.
    b = n_px;
    @(posedge clk); #1;
    push(0, 0, 20, 0, 7);
    wait_px("R");
    @(posedge clk);
    @(posedge clk); #1 rst_b = 1'b0;
    #1;
    check("R_pxWrite", 32'(bus.pxWrite), 32'd0);
    check("R_busy",    32'(busy),        32'd0);
    check("R_pixel",   pk(bus.pxX, bus.pxY, bus.pxColor), pk(0, 0, 0));
    check("R_before",  32'(n_px - b),    32'd2);
    np = n_px;
    @(posedge clk); #1 rst_b = 1'b1;
    repeat (10) @(negedge clk);
    check("R_after_count", 32'(n_px - np), 32'd0);
    check("R_idle", 32'(busy), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
